// File: rtl/lsu_queue_pkg.sv
// Shared definitions for the load/store queue: default widths, the queue
// entry record and a constructor for freshly enqueued entries.
package lsu_queue_pkg;

  localparam int lsu_addr_width_c = 32;
  localparam int lsu_data_width_c = 32;
  localparam int lsu_depth_c      = 4;
  localparam int lsu_rd_width_c   = 5;

  typedef logic [lsu_addr_width_c-1:0] lsu_addr_t;
  typedef logic [lsu_data_width_c-1:0] lsu_data_t;
  typedef logic [lsu_rd_width_c-1:0]   lsu_rd_t;

  // byte_op carries the byte_not_word flag ("byte" is a reserved word)
  typedef struct packed {
    logic      wen;
    logic      byte_op;
    lsu_addr_t addr;
    lsu_data_t wdata;
    lsu_rd_t   rd;
    logic      issued;
  } lsu_entry_t;

  function automatic lsu_entry_t lsu_make_entry(input logic      wen,
                                                input logic      byte_op,
                                                input lsu_addr_t addr,
                                                input lsu_data_t wdata,
                                                input lsu_rd_t   rd);
    lsu_entry_t e;
    e.wen     = wen;
    e.byte_op = byte_op;
    e.addr    = addr;
    e.wdata   = wdata;
    e.rd      = rd;
    e.issued  = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/lsu_tag_fifo.sv
// Entry storage with head (retire), issue and tail (enqueue) pointers.
// Entries between head and issue are in flight; issue to tail are waiting.
module lsu_tag_fifo
  import lsu_queue_pkg::*;
#(
  parameter int depth_p = lsu_depth_c
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_enq,
  input  lsu_entry_t                 i_enq_entry,
  input  logic                       i_issue,
  input  logic                       i_retire,
  output logic                       o_full,
  output logic [$clog2(depth_p):0]   o_count,
  output logic                       o_iss_valid,
  output logic                       o_iss_wen,
  output logic                       o_iss_byte,
  output lsu_addr_t                  o_iss_addr,
  output lsu_data_t                  o_iss_wdata,
  output logic                       o_head_issued,
  output logic                       o_head_wen,
  output lsu_rd_t                    o_head_rd
);

  localparam int ptr_w_lp = $clog2(depth_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [ptr_w_lp-1:0] ptr_one_lp = ptr_w_lp'(1);
  localparam logic [cnt_w_lp-1:0] cnt_one_lp = cnt_w_lp'(1);
  localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(depth_p);

  lsu_entry_t            r_mem [depth_p];
  logic [ptr_w_lp-1:0]   r_head;
  logic [ptr_w_lp-1:0]   r_tail;
  logic [ptr_w_lp-1:0]   r_iss;
  logic [cnt_w_lp-1:0]   r_count;
  logic                  w_iss_occupied;

  // pointer and occupancy bookkeeping; depth is a power of 2 so wrap is free
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_iss   <= '0;
      r_count <= '0;
    end else begin
      if (i_enq)    r_tail <= r_tail + ptr_one_lp;
      if (i_issue)  r_iss  <= r_iss + ptr_one_lp;
      if (i_retire) r_head <= r_head + ptr_one_lp;
      case ({i_enq, i_retire})
        2'b10:   r_count <= r_count + cnt_one_lp;
        2'b01:   r_count <= r_count - cnt_one_lp;
        default: r_count <= r_count;
      endcase
    end
  end

  // entry payloads; only the issued flags need a defined reset value
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < depth_p; i++) r_mem[i].issued <= 1'b0;
    end else begin
      if (i_enq)   r_mem[r_tail]       <= i_enq_entry;
      if (i_issue) r_mem[r_iss].issued <= 1'b1;
    end
  end

  assign o_full         = (r_count == cnt_max_lp);
  assign o_count        = r_count;
  assign w_iss_occupied = (r_iss != r_tail) | o_full;
  assign o_iss_valid    = w_iss_occupied & ~r_mem[r_iss].issued;
  assign o_iss_wen      = r_mem[r_iss].wen;
  assign o_iss_byte     = r_mem[r_iss].byte_op;
  assign o_iss_addr     = r_mem[r_iss].addr;
  assign o_iss_wdata    = r_mem[r_iss].wdata;
  assign o_head_issued  = (r_count != '0) & r_mem[r_head].issued;
  assign o_head_wen     = r_mem[r_head].wen;
  assign o_head_rd      = r_mem[r_head].rd;

endmodule

// File: rtl/lsu_queue.sv
// In-order load/store queue: accepts LD/ST requests, issues them to data
// memory one at a time, and retires them in order as responses arrive.
module lsu_queue
  import lsu_queue_pkg::*;
#(
  parameter int addr_width_p = lsu_addr_width_c,
  parameter int data_width_p = lsu_data_width_c,
  parameter int depth_p      = lsu_depth_c,
  parameter int rd_width_p   = lsu_rd_width_c
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid_i,
  input  logic                     req_wen_i,
  input  logic                     req_byte_i,
  input  logic [addr_width_p-1:0]  req_addr_i,
  input  logic [data_width_p-1:0]  req_wdata_i,
  input  logic [rd_width_p-1:0]    req_rd_i,
  output logic                     req_ready_o,
  output logic                     mem_valid_o,
  output logic                     mem_wen_o,
  output logic                     mem_byte_o,
  output logic [addr_width_p-1:0]  mem_addr_o,
  output logic [data_width_p-1:0]  mem_wdata_o,
  input  logic                     mem_yumi_i,
  input  logic                     mem_rvalid_i,
  input  logic [data_width_p-1:0]  mem_rdata_i,
  output logic                     mem_yumi_o,
  output logic                     resp_valid_o,
  output logic                     resp_is_load_o,
  output logic [rd_width_p-1:0]    resp_rd_o,
  output logic [data_width_p-1:0]  resp_data_o,
  input  logic                     resp_yumi_i,
  output logic [$clog2(depth_p):0] count_o,
  output logic                     busy_o,
  output logic                     error_o
);

  logic       w_full;
  logic       w_enq;
  logic       w_issue;
  logic       w_retire;
  logic       w_iss_valid;
  logic       w_iss_wen;
  logic       w_iss_byte;
  lsu_addr_t  w_iss_addr;
  lsu_data_t  w_iss_wdata;
  logic       w_head_issued;
  logic       w_head_wen;
  lsu_rd_t    w_head_rd;
  lsu_entry_t w_enq_entry;
  logic       r_error;

  assign w_enq_entry = lsu_make_entry(req_wen_i, req_byte_i, lsu_addr_t'(req_addr_i),
                                      lsu_data_t'(req_wdata_i), lsu_rd_t'(req_rd_i));

  lsu_tag_fifo #(.depth_p(depth_p)) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .i_enq         (w_enq),
    .i_enq_entry   (w_enq_entry),
    .i_issue       (w_issue),
    .i_retire      (w_retire),
    .o_full        (w_full),
    .o_count       (count_o),
    .o_iss_valid   (w_iss_valid),
    .o_iss_wen     (w_iss_wen),
    .o_iss_byte    (w_iss_byte),
    .o_iss_addr    (w_iss_addr),
    .o_iss_wdata   (w_iss_wdata),
    .o_head_issued (w_head_issued),
    .o_head_wen    (w_head_wen),
    .o_head_rd     (w_head_rd)
  );

  // ready depends only on registered occupancy, never on a same-cycle retire
  assign req_ready_o  = ~w_full;
  assign w_enq        = req_valid_i & ~w_full;
  assign mem_valid_o  = w_iss_valid;
  assign w_issue      = w_iss_valid & mem_yumi_i;
  assign resp_valid_o = mem_rvalid_i & w_head_issued;
  assign w_retire     = resp_valid_o & resp_yumi_i;
  assign mem_yumi_o   = w_retire;
  assign resp_data_o  = mem_rdata_i;
  assign busy_o       = (count_o != '0);
  assign error_o      = r_error;

  // memory request fields, held at zero when nothing is presentable
  always_comb begin
    mem_wen_o   = 1'b0;
    mem_byte_o  = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_iss_valid) begin
      mem_wen_o   = w_iss_wen;
      mem_byte_o  = w_iss_byte;
      mem_addr_o  = w_iss_addr[addr_width_p-1:0];
      mem_wdata_o = w_iss_wdata[data_width_p-1:0];
    end else begin
      mem_wen_o   = 1'b0;
      mem_byte_o  = 1'b0;
    end
  end

  // response tag fields for the head entry
  always_comb begin
    resp_is_load_o = 1'b0;
    resp_rd_o      = '0;
    if (resp_valid_o) begin
      resp_is_load_o = ~w_head_wen;
      resp_rd_o      = w_head_rd[rd_width_p-1:0];
    end else begin
      resp_is_load_o = 1'b0;
    end
  end

  // a response with nothing in flight is a sticky protocol error
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_error <= 1'b0;
    end else if (mem_rvalid_i & ~w_head_issued) begin
      r_error <= 1'b1;
    end else begin
      r_error <= r_error;
    end
  end

endmodule

// File: tb/tb_lsu_queue.sv
// Self-checking bench for lsu_queue (depth 4): reference queue model as a
// scoreboard, a vector table for the fill sequence, and hand-written corners.
module tb_lsu_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i, req_wen_i, req_byte_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        req_ready_o;
  logic        mem_valid_o, mem_wen_o, mem_byte_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_yumi_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_yumi_o;
  logic        resp_valid_o, resp_is_load_o;
  logic [4:0]  resp_rd_o;
  logic [31:0] resp_data_o;
  logic        resp_yumi_i;
  logic [2:0]  count_o;
  logic        busy_o, error_o;

  always #5 clk = ~clk;

  lsu_queue #(.addr_width_p(32), .data_width_p(32), .depth_p(4), .rd_width_p(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_wen_i(req_wen_i), .req_byte_i(req_byte_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .req_ready_o(req_ready_o),
    .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o), .mem_byte_o(mem_byte_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_yumi_i(mem_yumi_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_yumi_o(mem_yumi_o),
    .resp_valid_o(resp_valid_o), .resp_is_load_o(resp_is_load_o), .resp_rd_o(resp_rd_o),
    .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
    .count_o(count_o), .busy_o(busy_o), .error_o(error_o)
  );

  typedef struct {
    logic        wen;
    logic        bt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } ment_t;

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic [4:0]  rd;
    int          e_cnt;
    logic        e_ready;
    logic        e_mv;
    logic [31:0] e_maddr;
  } vec_t;

  int    checks   = 0;
  int    failures = 0;
  int    mcnt     = 0;
  int    retired  = 0;
  logic  merr     = 1'b0;
  logic  exp_ready, exp_mv, exp_rv;
  ment_t pend[$];
  ment_t outq[$];
  vec_t  tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // drive one cycle of inputs and compare every output against the model
  task automatic drive(input logic rv, input logic wen, input logic bt,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic myumi, input logic rvalid,
                       input logic [31:0] rdata, input logic ryumi);
    req_valid_i = rv; req_wen_i = wen; req_byte_i = bt; req_addr_i = addr;
    req_wdata_i = wdata; req_rd_i = rd; mem_yumi_i = myumi; mem_rvalid_i = rvalid;
    mem_rdata_i = rdata; resp_yumi_i = ryumi;
    #1;
    exp_ready = (mcnt < 4);
    exp_mv    = (pend.size() != 0);
    exp_rv    = rvalid && (outq.size() != 0);
    chk("req_ready", req_ready_o, exp_ready);
    chk("count", count_o, mcnt);
    chk("busy", busy_o, mcnt != 0);
    chk("mem_valid", mem_valid_o, exp_mv);
    if (exp_mv) begin
      chk("mem_addr", mem_addr_o, pend[0].addr);
      chk("mem_wen", mem_wen_o, pend[0].wen);
      chk("mem_byte", mem_byte_o, pend[0].bt);
      chk("mem_wdata", mem_wdata_o, pend[0].wdata);
    end
    chk("resp_valid", resp_valid_o, exp_rv);
    if (exp_rv) begin
      chk("resp_rd", resp_rd_o, outq[0].rd);
      chk("resp_is_load", resp_is_load_o, !outq[0].wen);
      chk("resp_data", resp_data_o, rdata);
    end
    chk("mem_yumi_o", mem_yumi_o, exp_rv && ryumi);
    chk("error", error_o, merr);
  endtask

  // clock edge plus reference-model update
  task automatic advance();
    ment_t e;
    @(posedge clk);
    if (mem_rvalid_i && outq.size() == 0) merr = 1'b1;
    if (exp_rv && resp_yumi_i) begin
      void'(outq.pop_front());
      mcnt--;
      retired++;
    end
    if (exp_mv && mem_yumi_i) outq.push_back(pend.pop_front());
    if (req_valid_i && exp_ready) begin
      e.wen = req_wen_i; e.bt = req_byte_i; e.addr = req_addr_i;
      e.wdata = req_wdata_i; e.rd = req_rd_i;
      pend.push_back(e);
      mcnt++;
    end
    #1;
  endtask

  task automatic cyc(input logic rv, input logic wen, input logic [31:0] addr,
                     input logic [4:0] rd, input logic myumi, input logic rvalid,
                     input logic [31:0] rdata, input logic ryumi);
    drive(rv, wen, 1'b0, addr, addr ^ 32'h5A5A_0000, rd, myumi, rvalid, rdata, ryumi);
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid_i = 1'b0; req_wen_i = 1'b0; req_byte_i = 1'b0; req_addr_i = 32'h0;
    req_wdata_i = 32'h0; req_rd_i = 5'h0; mem_yumi_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i = 32'h0; resp_yumi_i = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready", req_ready_o, 1'b1);
    chk("rst_mem_valid", mem_valid_o, 1'b0);
    chk("rst_resp_valid", resp_valid_o, 1'b0);
    chk("rst_mem_yumi", mem_yumi_o, 1'b0);
    chk("rst_count", count_o, 3'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_error", error_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    reset = 1'b1;
    pend.delete(); outq.delete(); mcnt = 0; merr = 1'b0;
  endtask

  // issue and retire everything outstanding, bounded
  task automatic drain();
    for (int k = 0; k < 40 && mcnt != 0; k++)
      cyc(1'b0, 1'b0, 32'h0, 5'h0, 1'b1, outq.size() != 0, 32'hC0DE_0000 + k, 1'b1);
    chk("drained_count", count_o, 3'd0);
  endtask

  initial begin
    int sent, pair_ret;
    logic [31:0] exp_maddr;

    tbl[0] = '{1'b1, 32'h10, 5'd0, 0, 1'b1, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h11, 5'd1, 1, 1'b1, 1'b1, 32'h10};
    tbl[2] = '{1'b1, 32'h12, 5'd2, 2, 1'b1, 1'b1, 32'h10};
    tbl[3] = '{1'b1, 32'h13, 5'd3, 3, 1'b1, 1'b1, 32'h10};
    tbl[4] = '{1'b0, 32'h0,  5'd0, 4, 1'b0, 1'b1, 32'h10};
    tbl[5] = '{1'b1, 32'h99, 5'd7, 4, 1'b0, 1'b1, 32'h10};
    tbl[6] = '{1'b0, 32'h0,  5'd0, 4, 1'b0, 1'b1, 32'h10};

    do_reset();

    // fill to full with mem_yumi_i low; head request must stay put
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].rv, 1'b0, 1'b0, tbl[i].addr, 32'h0, tbl[i].rd, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("tbl_count", count_o, tbl[i].e_cnt);
      chk("tbl_ready", req_ready_o, tbl[i].e_ready);
      chk("tbl_mem_valid", mem_valid_o, tbl[i].e_mv);
      if (tbl[i].e_mv) chk("tbl_mem_addr", mem_addr_o, tbl[i].e_maddr);
      advance();
    end

    // issue all four in order
    for (int k = 0; k < 4; k++) begin
      exp_maddr = 32'h10 + k;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("issue_order_addr", mem_addr_o, exp_maddr);
      advance();
    end

    // full: enqueue in the same cycle as a retire is rejected, next cycle accepted
    drive(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 5'd9, 1'b0, 1'b1, 32'h1111, 1'b1);
    chk("full_retire_ready", req_ready_o, 1'b0);
    advance();
    chk("full_retire_count", count_o, 3'd3);
    drive(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 5'd9, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("refill_ready", req_ready_o, 1'b1);
    advance();
    chk("refill_count", count_o, 3'd4);

    // response held off by the pipeline for three cycles
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b1, 32'h2222, 1'b0);
      chk("stall_mem_yumi", mem_yumi_o, 1'b0);
      chk("stall_resp_valid", resp_valid_o, 1'b1);
      advance();
      chk("stall_count", count_o, 3'd4);
    end
    drain();

    // single load round trip
    cyc(1'b1, 1'b0, 32'h20, 5'd3, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    chk("single_rd", resp_rd_o, 5'd3);
    chk("single_data", resp_data_o, 32'hDEADBEEF);
    chk("single_mem_yumi", mem_yumi_o, 1'b1);
    chk("single_count_before", count_o, 3'd1);
    advance();
    chk("single_count_after", count_o, 3'd0);

    // mem_yumi_i with nothing to issue is ignored
    cyc(1'b0, 1'b0, 32'h0, 5'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h40, 5'd4, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("stray_yumi_valid", mem_valid_o, 1'b1);
    chk("stray_yumi_addr", mem_addr_o, 32'h40);
    advance();
    drain();

    // ten back-to-back store/load pairs, wrapping the pointers
    sent = 0; pair_ret = 0;
    for (int k = 0; k < 200 && pair_ret < 20; k++) begin
      drive(sent < 20, (sent % 2) == 0, sent[2], 32'h100 + sent, 32'hA000 + sent,
            sent[4:0], 1'b1, outq.size() != 0, 32'hB000 + k, 1'b1);
      if (exp_rv) begin
        chk("pair_alternate", resp_is_load_o, (pair_ret % 2) == 1);
        pair_ret++;
      end
      if (sent < 20 && exp_ready) sent++;
      advance();
    end
    chk("pair_retired", pair_ret, 20);
    chk("pair_error", error_o, 1'b0);
    chk("pair_count", count_o, 3'd0);

    // stray response on an empty queue -> sticky error
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b1, 32'h3333, 1'b1);
    chk("stray_resp_valid", resp_valid_o, 1'b0);
    chk("stray_mem_yumi", mem_yumi_o, 1'b0);
    advance();
    chk("stray_error", error_o, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("stray_error_sticky", error_o, 1'b1);
    do_reset();

    // reset mid-flight drops entries; the late response is then an error
    cyc(1'b1, 1'b0, 32'h50, 5'd5, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    do_reset();
    cyc(1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b1, 32'h4444, 1'b1);
    chk("stale_error", error_o, 1'b1);
    chk("stale_count", count_o, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
